workload_exec: RTL
==================

// Module: workload_exec
// PURPOSE
// Downstream consumer for the multi-port workload generator. Accepts {id,size} workload
// records from num_ports_p valid/ready ports via round-robin arbitration and models execution
// by holding busy for max(size,1) cycles. Emits one completion record per workload on a
// valid/yumi output and keeps accept/complete counters for testbench scoreboarding.
// PARAMETERS
// id_width_p    8   width of the workload id field (upper field of data_i)
// size_width_p  16  width of the workload size field (lower field of data_i)
// num_ports_p   2   number of input ports; must be >= 1
// cnt_width_p   32  width of the statistics counters
// width_lp      id_width_p+size_width_p; packed record width, derived, do not override
// PORTS
// clk_i          in   1                          single clock, rising edge
// reset_i        in   1                          asynchronous, active-high reset
// v_i            in   num_ports_p                per-port workload valid
// data_i         in   num_ports_p x width_lp     per-port {id, size}
// ready_o        in/o out num_ports_p            per-port ready; at most one bit set (one-hot grant)
// done_v_o       out  1                          completion record valid
// done_port_o    out  clog2(num_ports_p) safe    source port of the completed workload
// done_id_o      out  id_width_p                 id of the completed workload
// done_cycles_o  out  size_width_p+1             cycles spent in EXEC
// done_yumi_i    in   1                          consumer takes the record; legal only while done_v_o
// busy_o         out  1                          state != IDLE
// accept_cnt_o   out  cnt_width_p                workloads accepted since reset
// done_cnt_o     out  cnt_width_p                completion records consumed since reset
// BEHAVIOUR
// - Reset (async, immediate): state=IDLE; ready_o=0; done_v_o=0; all done_* fields=0;
//   busy_o=0; both counters=0; RR pointer=num_ports_p-1, so port 0 has top priority.
//   Reset mid-EXEC or mid-REPORT discards the in-flight record. No accept on the deassert edge.
// - FSM states: IDLE -> EXEC -> REPORT -> IDLE.
// - IDLE: ready_o = grant, where grant is the RR choice among the set v_i bits, searched from ptr+1
//   upward with wrap-around. ready_o may depend combinationally on v_i; v_i must not depend on ready_o.
//   Transfer = v_i[g] & ready_o[g]. On transfer: latch port g, id, and size; set the cycle counter
//   to max(size,1); ptr<=g; accept_cnt++; go to EXEC. If no v_i bit is set, stay in IDLE.
// - EXEC: ready_o=0. The counter decrements by 1 each cycle and the elapsed count increments.
//   When the counter reaches 1, go to REPORT. EXEC lasts exactly max(size,1) cycles.
// - REPORT: done_v_o=1 with done_* held stable. On done_yumi_i: done_cnt++ and go to IDLE.
//   A new accept is possible in the cycle after yumi. There is no bypass, so throughput is at most
//   1 workload per max(size,1)+2 cycles.
// - Latency: transfer at edge T, then EXEC cycles T+1..T+s, then done_v_o first high in cycle T+s+1
//   (s = max(size,1)).
// - size==0 is treated as 1 cycle. done_cycles_o reports 1 for size==0 and equals size otherwise.
// - Both counters wrap modulo 2^cnt_width_p.
// - num_ports_p==1: the arbiter degenerates to ready_o = v_i & IDLE, and done_port_o=0.
// STRUCTURE
// - workload_pkg: typedef enum logic [1:0] {eIdle, eExec, eReport} workload_exec_state_e;
//   completion record struct {port, id, cycles}.
// - Sub-module workload_rr_arb #(num_ports_p): inputs reqs_i, ptr_i, en_i; outputs one-hot
//   grant_o and grant_id_o. Purely combinational. The pointer register lives in workload_exec.
// - All flops use async reset on reset_i.
// TESTING
// 1 Reset then v_i=2'b01, port0 {id=3,size=4}, yumi tied 1 -> ready_o[0] for 1 cycle;
//   done_v_o 5 cycles after the transfer; done_id=3, done_cycles=4, done_port=0.
// 2 Both ports valid continuously -> grants alternate 0,1,0,1; after 4 records the done_port
//   sequence is 0,1,0,1 and accept_cnt=done_cnt=4.
// 3 size=0 on port1 -> EXEC lasts 1 cycle, done_cycles=1; size=65535 -> done_cycles=65535,
//   with no early exit.
// 4 done_yumi_i held 0 for 10 cycles in REPORT -> done_v_o and fields stable; ready_o=0
//   throughout; the accept happens only after yumi.
// 5 Assert reset_i mid-EXEC (asynchronously, off the clock edge) -> busy_o, ready_o and done_v_o
//   drop immediately; counters read 0; the next workload is processed normally.
// 6 Drive with the workload generator (2 ports, workload_limit=8, gen_freq=0) -> 16 completions,
//   ids 0..7 per port each seen exactly once, in order per port.

Source files
------------

// File: rtl/workload_pkg.sv
// Shared types and helpers for the workload execution consumer and its arbiter.
package workload_pkg;

    typedef enum logic [1:0] {
        eIdle   = 2'd0,
        eExec   = 2'd1,
        eReport = 2'd2
    } workload_exec_state_e;

    // Port-index width that stays legal for a single-port build.
    function automatic int workload_port_width(input int num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

endpackage

// File: rtl/workload_rr_arb.sv
// Combinational round-robin arbiter: searches upward from ptr_i+1 with wrap-around
// and returns a one-hot grant plus its index. The pointer register lives in the caller.
module workload_rr_arb
    import workload_pkg::*;
#(
    parameter  int num_ports_p = 2,
    localparam int port_w_lp   = workload_port_width(num_ports_p)
) (
    input  logic [num_ports_p-1:0] reqs_i,
    input  logic [port_w_lp-1:0]   ptr_i,
    input  logic                   en_i,
    output logic [num_ports_p-1:0] grant_o,
    output logic [port_w_lp-1:0]   grant_id_o
);

    always_comb begin
        int   idx;
        logic found;
        idx        = 0;
        found      = 1'b0;
        grant_o    = '0;
        grant_id_o = '0;
        for (int i = 1; i <= num_ports_p; i++) begin
            idx = (int'(ptr_i) + i) % num_ports_p;
            if (en_i && !found && reqs_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                grant_id_o   = port_w_lp'(idx);
            end
        end
    end

endmodule

// File: rtl/workload_exec.sv
// Workload consumer: round-robin accept of {id,size} records, busy for max(size,1)
// cycles, then one completion record on a valid/yumi handshake.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  eIdle   | ready offered to the RR winner; transfer latches the record
//  eExec   | timer counts down from max(size,1); elapsed count climbs
//  eReport | done_v_o high with fields held until done_yumi_i
module workload_exec
    import workload_pkg::*;
#(
    parameter  int id_width_p   = 8,
    parameter  int size_width_p = 16,
    parameter  int num_ports_p  = 2,
    parameter  int cnt_width_p  = 32,
    localparam int width_lp     = id_width_p + size_width_p,
    localparam int port_w_lp    = workload_port_width(num_ports_p)
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic [num_ports_p-1:0]               v_i,
    input  logic [num_ports_p-1:0][width_lp-1:0] data_i,
    output logic [num_ports_p-1:0]               ready_o,
    output logic                                 done_v_o,
    output logic [port_w_lp-1:0]                 done_port_o,
    output logic [id_width_p-1:0]                done_id_o,
    output logic [size_width_p:0]                done_cycles_o,
    input  logic                                 done_yumi_i,
    output logic                                 busy_o,
    output logic [cnt_width_p-1:0]               accept_cnt_o,
    output logic [cnt_width_p-1:0]               done_cnt_o
);

    typedef struct packed {
        logic [port_w_lp-1:0]  port;
        logic [id_width_p-1:0] id;
        logic [size_width_p:0] cycles;
    } done_rec_s;

    workload_exec_state_e    state_r;
    logic [port_w_lp-1:0]    ptr_r;
    logic [size_width_p-1:0] timer_r;
    done_rec_s               rec_r;
    logic [cnt_width_p-1:0]  accept_cnt_r;
    logic [cnt_width_p-1:0]  done_cnt_r;

    logic [num_ports_p-1:0]  grant;
    logic [port_w_lp-1:0]    grant_id;
    logic [id_width_p-1:0]   id_in;
    logic [size_width_p-1:0] size_in;
    logic                    arb_en;
    logic                    xfer;
    logic                    yumi;

    // Gating on reset_i keeps ready_o low while reset is held, even though state is IDLE.
    assign arb_en = (state_r == eIdle) & ~reset_i;

    workload_rr_arb #(.num_ports_p(num_ports_p)) arb (
        .reqs_i     (v_i),
        .ptr_i      (ptr_r),
        .en_i       (arb_en),
        .grant_o    (grant),
        .grant_id_o (grant_id)
    );

    assign ready_o           = grant;
    assign xfer              = |grant;
    assign {id_in, size_in}  = data_i[grant_id];
    assign yumi              = (state_r == eReport) & done_yumi_i;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r      <= eIdle;
            ptr_r        <= port_w_lp'(num_ports_p - 1);
            timer_r      <= '0;
            rec_r        <= '0;
            accept_cnt_r <= '0;
            done_cnt_r   <= '0;
        end else begin
            case (state_r)
                eIdle: begin
                    if (xfer) begin
                        state_r      <= eExec;
                        ptr_r        <= grant_id;
                        rec_r.port   <= grant_id;
                        rec_r.id     <= id_in;
                        rec_r.cycles <= '0;
                        timer_r      <= (size_in == '0) ? size_width_p'(1) : size_in;
                        accept_cnt_r <= accept_cnt_r + cnt_width_p'(1);
                    end
                end
                eExec: begin
                    rec_r.cycles <= rec_r.cycles + (size_width_p + 1)'(1);
                    if (timer_r == size_width_p'(1)) begin
                        state_r <= eReport;
                    end else begin
                        timer_r <= timer_r - size_width_p'(1);
                    end
                end
                eReport: begin
                    if (yumi) begin
                        state_r    <= eIdle;
                        done_cnt_r <= done_cnt_r + cnt_width_p'(1);
                    end
                end
                default: state_r <= eIdle;
            endcase
        end
    end

    assign busy_o        = (state_r != eIdle);
    assign done_v_o      = (state_r == eReport);
    assign done_port_o   = rec_r.port;
    assign done_id_o     = rec_r.id;
    assign done_cycles_o = rec_r.cycles;
    assign accept_cnt_o  = accept_cnt_r;
    assign done_cnt_o    = done_cnt_r;

endmodule
